// File: rtl/axil_pkg.sv
// axil_pkg: shared definitions for the AXI4-Lite register file slave.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   wstate_e                : write-channel FSM states (W_IDLE, W_RESP)
//   clog2                   : constant ceil(log2) helper for address decode
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// axil_wstrb_merge: combinational byte-lane merge of a write into an existing word.
//   old_word : current register contents
//   wdata    : incoming write data
//   wstrb    : per-byte enable, 1 = take wdata lane
//   merged   : resulting word
module axil_wstrb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   merged
);

  for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
    assign merged[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_word[b*8 +: 8];
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: parametrised AXI4-Lite slave register file.
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response channels
//   S_AXI_AR* / S_AXI_R*            : read address, data channels
//   reg_out  : flat register image, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse : one-cycle strobe per register on the cycle its new value appears
// Build option: define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses
// with SLVERR; otherwise they return OKAY (side effects identical either way).
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = clog2(SW);
  localparam int IDX_W    = AW - ADDR_LSB;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif

  // Readies stay low through reset and the first clock after release.
  logic ready_en;

  wstate_e                     w_state, w_state_nxt;
  logic                        aw_held, w_held;
  logic [IDX_W-1:0]            aw_idx_q;
  logic [DW-1:0]               w_data_q;
  logic [SW-1:0]               w_strb_q;
  logic                        aw_hs, w_hs, commit;
  logic [IDX_W-1:0]            wr_idx;
  logic [DW-1:0]               wr_data, wr_old, wr_merged;
  logic [SW-1:0]               wr_strb;
  logic                        wr_hit;
  logic [NUM_REGS-1:0]         wr_sel;
  logic [1:0]                  bresp_q;
  logic [NUM_REGS-1:0]         wr_pulse_q;
  logic [NUM_REGS-1:0][DW-1:0] regs;

  logic                        ar_hs, rd_hit;
  logic [IDX_W-1:0]            rd_idx;
  logic [DW-1:0]               rd_word;
  logic                        rvalid_q;
  logic [DW-1:0]               rdata_q;
  logic [1:0]                  rresp_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  // ---------------- write path ----------------
  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
  assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // Held copy wins; otherwise the live channel is handshaking this cycle.
  assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[AW-1:ADDR_LSB];
  assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;
  assign wr_hit  = 32'(wr_idx) < NUM_REGS;

  always_comb begin
    wr_sel = '0;
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(wr_idx) == 32'(i)) begin
        wr_sel[i] = 1'b1;
        wr_old    = regs[i];
      end
    end
  end

  axil_wstrb_merge #(.DATA_W(DW)) u_merge (
    .old_word (wr_old),
    .wdata    (wr_data),
    .wstrb    (wr_strb),
    .merged   (wr_merged)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (commit)       w_state_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default:                   w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en && !aw_held;
        S_AXI_WREADY  = ready_en && !w_held;
      end
      W_RESP:  S_AXI_BVALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[AW-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel[i]) regs[i] <= wr_merged;
    end
  end

  // wr_sel is all-zero for out-of-range indices, so the pulse drops too.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= commit ? wr_sel : '0;
      if (commit) bresp_q <= wr_hit ? RESP_OKAY : ERR_RESP;
    end
  end

  assign S_AXI_BRESP = bresp_q;
  assign wr_pulse    = wr_pulse_q;
  assign reg_out     = regs;

  // ---------------- read path ----------------
  assign S_AXI_ARREADY = ready_en && (!rvalid_q || S_AXI_RREADY);
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx        = S_AXI_ARADDR[AW-1:ADDR_LSB];
  assign rd_hit        = 32'(rd_idx) < NUM_REGS;

  // No match for out-of-range indices leaves the word at zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(rd_idx) == 32'(i)) rd_word = regs[i];
  end

  // Sampling regs here (pre-edge) returns the old value on a same-cycle commit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_hit ? RESP_OKAY : ERR_RESP;
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: directed self-checking bench for axil_regfile_slave
// (32-bit data, 6-bit address, 8 registers, nonzero reset value).
module tb_axil_regfile_slave;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam logic [DW-1:0] RV = 32'hA5A5_0000;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0] wr_pulse;

  logic [NR-1:0][DW-1:0] exp_img;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_regfile_slave #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE(RV)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
    int n;
    n = 0;
    araddr = a; arvalid = 1; rready = 1;
    do begin tick(); n++; end while (!rvalid && n < 20);
    arvalid = 0;
    d = rdata; r = rresp;
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h rvalid=%b want 1", a, rvalid);
    end
    tick();
    rready = 0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    logic [1:0] r;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl got=%b want=00000", {awready, wready, bvalid, arready, rvalid}); end
    checks++; if ({bresp, rresp, rdata} !== 36'h0) begin errors++;
      $display("FAIL reset_resp_data got=%h want=0", {bresp, rresp, rdata}); end
    checks++; if (wr_pulse !== 8'h00) begin errors++;
      $display("FAIL reset_pulse got=%h want=00", wr_pulse); end
    checks++; if (reg_out !== exp_img) begin errors++;
      $display("FAIL reset_img got=%h want=%h", reg_out, exp_img); end
    rst_n = 1;
    tick(); tick();
    for (int i = 0; i < NR; i++) begin
      axi_read(6'(i*4), d, r);
      checks++; if ({r, d} !== {2'b00, RV}) begin errors++;
        $display("FAIL reset_read%0d got=%h/%b want=%h/00", i, d, r, RV); end
    end
    // W held, then reset drops it: a later AW alone must not commit.
    wdata = 32'h1111_1111; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    checks++; if (wready !== 1'b0) begin errors++;
      $display("FAIL held_w_wready got=%b want=0", wready); end
    rst_n = 0;
    #1;
    checks++; if ({bvalid, wready} !== 2'b00) begin errors++;
      $display("FAIL midreset_async got=%b want=00", {bvalid, wready}); end
    tick(); rst_n = 1; tick(); tick();
    checks++; if (wready !== 1'b1) begin errors++;
      $display("FAIL midreset_wcleared wready=%b want 1", wready); end
    awaddr = 6'h04; awvalid = 1;
    tick();
    awvalid = 0;
    tick();
    checks++; if ({bvalid, reg_out[1*DW +: DW]} !== {1'b0, RV}) begin errors++;
      $display("FAIL midreset_dropped got=%b/%h want=0/%h", bvalid, reg_out[1*DW +: DW], RV); end
    // WSTRB=0 completes the pending AW as a no-op that still responds.
    wdata = 32'hFFFF_FFFF; wstrb = 4'h0; wvalid = 1;
    tick();
    wvalid = 0;
    checks++; if ({bvalid, bresp, wr_pulse, reg_out[1*DW +: DW]} !== {1'b1, 2'b00, 8'h02, RV}) begin errors++;
      $display("FAIL strb0_noop got=%b/%b/%h/%h want=1/00/02/%h", bvalid, bresp, wr_pulse, reg_out[1*DW +: DW], RV); end
    bready = 1; tick(); bready = 0;
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    logic [1:0] r;
    awaddr = 6'h08; awvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
    checks++; if ({awready, wready} !== 2'b11) begin errors++;
      $display("FAIL same_ready got=%b want=11", {awready, wready}); end
    tick();
    awvalid = 0; wvalid = 0;
    exp_img[2] = 32'hDEAD_BEEF;
    checks++; if ({bvalid, bresp, wr_pulse} !== {1'b1, 2'b00, 8'h04}) begin errors++;
      $display("FAIL same_resp got=%b/%b/%h want=1/00/04", bvalid, bresp, wr_pulse); end
    checks++; if (reg_out !== exp_img) begin errors++;
      $display("FAIL same_img got=%h want=%h", reg_out, exp_img); end
    bready = 1; tick(); bready = 0;
    checks++; if ({bvalid, wr_pulse} !== 9'h0) begin errors++;
      $display("FAIL same_done got=%b/%h want=0/00", bvalid, wr_pulse); end
    axi_read(6'h08, d, r);
    checks++; if ({r, d} !== {2'b00, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL same_read got=%h/%b want=deadbeef/00", d, r); end
  endtask

  task automatic test_aw_skew();
    wdata = 32'h0000_CAFE; wstrb = 4'h3; wvalid = 1;
    tick();
    wvalid = 0;
    for (int c = 0; c < 2; c++) begin
      checks++; if ({wready, bvalid} !== 2'b00) begin errors++;
        $display("FAIL skew_hold%0d got=%b want=00", c, {wready, bvalid}); end
      tick();
    end
    checks++; if (wready !== 1'b0) begin errors++;
      $display("FAIL skew_hold2 wready=%b want 0", wready); end
    awaddr = 6'h08; awvalid = 1;
    tick();
    awvalid = 0;
    exp_img[2] = 32'hDEAD_CAFE;
    checks++; if ({bvalid, wr_pulse, reg_out[2*DW +: DW]} !== {1'b1, 8'h04, 32'hDEAD_CAFE}) begin errors++;
      $display("FAIL skew_merge got=%b/%h/%h want=1/04/deadcafe", bvalid, wr_pulse, reg_out[2*DW +: DW]); end
    bready = 1; tick(); bready = 0;
  endtask

  task automatic test_b_backpressure();
    awaddr = 6'h0C; awvalid = 1; wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    exp_img[3] = 32'h1122_3344;
    awaddr = 6'h10;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({bvalid, bresp, awready, wready} !== {1'b1, 2'b00, 2'b00}) begin errors++;
        $display("FAIL bstall%0d got=%b/%b/%b/%b want=1/00/0/0", c, bvalid, bresp, awready, wready); end
      tick();
    end
    bready = 1; tick(); bready = 0;
    checks++; if ({bvalid, awready} !== 2'b01) begin errors++;
      $display("FAIL bstall_release got=%b want=01", {bvalid, awready}); end
    tick();
    awvalid = 0;
    checks++; if ({awready, bvalid, reg_out[4*DW +: DW]} !== {2'b00, RV}) begin errors++;
      $display("FAIL bstall_awheld got=%b/%b/%h want=0/0/%h", awready, bvalid, reg_out[4*DW +: DW], RV); end
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    exp_img[4] = 32'h0000_0055;
    checks++; if ({bvalid, wr_pulse} !== {1'b1, 8'h10} || reg_out !== exp_img) begin errors++;
      $display("FAIL bstall_commit got=%b/%h/%h want=1/10/%h", bvalid, wr_pulse, reg_out, exp_img); end
    bready = 1; tick(); bready = 0;
  endtask

  task automatic test_read();
    logic [AW-1:0] addrs [4] = '{6'h00, 6'h04, 6'h0C, 6'h10};
    logic [DW-1:0] exps [4];
    exps = '{RV, RV, 32'h1122_3344, 32'h0000_0055};
    araddr = 6'h0C; arvalid = 1; rready = 0;
    tick();
    araddr = 6'h08;
    for (int c = 0; c < 3; c++) begin
      checks++; if ({rvalid, arready, rdata} !== {2'b10, 32'h1122_3344}) begin errors++;
        $display("FAIL rstall%0d got=%b/%b/%h want=1/0/11223344", c, rvalid, arready, rdata); end
      tick();
    end
    rready = 1;
    tick();
    checks++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hDEAD_CAFE}) begin errors++;
      $display("FAIL rstall_next got=%b/%b/%h want=1/00/deadcafe", rvalid, rresp, rdata); end
    for (int k = 0; k < 4; k++) begin
      araddr = addrs[k];
      tick();
      checks++; if ({rvalid, rdata} !== {1'b1, exps[k]}) begin errors++;
        $display("FAIL b2b%0d got=%b/%h want=1/%h", k, rvalid, rdata, exps[k]); end
    end
    arvalid = 0;
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++;
      $display("FAIL b2b_drain rvalid=%b want 0", rvalid); end
    rready = 0;
  endtask

  task automatic test_rw_collision();
    awaddr = 6'h0C; awvalid = 1; wdata = 32'h9999_9999; wstrb = 4'hF; wvalid = 1;
    araddr = 6'h0C; arvalid = 1; rready = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_img[3] = 32'h9999_9999;
    checks++; if ({rvalid, rdata} !== {1'b1, 32'h1122_3344}) begin errors++;
      $display("FAIL collide_read got=%b/%h want=1/11223344", rvalid, rdata); end
    checks++; if ({bvalid, reg_out[3*DW +: DW]} !== {1'b1, 32'h9999_9999}) begin errors++;
      $display("FAIL collide_write got=%b/%h want=1/99999999", bvalid, reg_out[3*DW +: DW]); end
    bready = 1; tick(); bready = 0; rready = 0;
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] d;
    logic [1:0] r;
    awaddr = 6'h3C; awvalid = 1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    checks++; if ({bvalid, bresp, wr_pulse} !== {1'b1, EXP_ERR, 8'h00}) begin errors++;
      $display("FAIL oor_wresp got=%b/%b/%h want=1/%b/00", bvalid, bresp, wr_pulse, EXP_ERR); end
    checks++; if (reg_out !== exp_img) begin errors++;
      $display("FAIL oor_img got=%h want=%h", reg_out, exp_img); end
    bready = 1; tick(); bready = 0;
    axi_read(6'h3C, d, r);
    checks++; if ({r, d} !== {EXP_ERR, 32'h0}) begin errors++;
      $display("FAIL oor_read3c got=%h/%b want=0/%b", d, r, EXP_ERR); end
    axi_read(6'h20, d, r);
    checks++; if ({r, d} !== {EXP_ERR, 32'h0}) begin errors++;
      $display("FAIL oor_read20 got=%h/%b want=0/%b", d, r, EXP_ERR); end
    axi_read(6'h1C, d, r);
    checks++; if ({r, d} !== {2'b00, RV}) begin errors++;
      $display("FAIL last_reg_read got=%h/%b want=%h/00", d, r, RV); end
    axi_read(6'h0B, d, r);
    checks++; if ({r, d} !== {2'b00, 32'hDEAD_CAFE}) begin errors++;
      $display("FAIL lowbits_read got=%h/%b want=deadcafe/00", d, r); end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) exp_img[i] = RV;
    test_reset();
    test_same_cycle();
    test_aw_skew();
    test_b_backpressure();
    test_read();
    test_rw_collision();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
